// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin resource arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_GUARD
    } arb_state_t;

    // Guard counter is fixed width; GUARD_CYCLES is limited to 0..15.
    localparam int GUARD_W = 4;

    // Bits needed to hold n_values distinct values, never less than one.
    function automatic int width_min1(input int n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

// File: rtl/rr_resource_arbiter_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner arbiter for a single shared resource: hold-until-done grant,
// per-grant timeout and a programmable idle guard gap between owners.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TIMEOUT      = 16,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     start,
    output logic                     timeout_pulse
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = width_min1(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(TIMEOUT);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               tmo_q, tmo_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               release_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        guard_d   = guard_q;
        tmo_d     = 1'b0;
        release_c = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_id_d = pick_idx;
                    hold_d   = HOLD_W'(1);
                    state_d  = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                // Release causes in priority order: done, abandoned request, timeout.
                if (done[gnt_id_q] || !req[gnt_id_q]) begin
                    release_c = 1'b1;
                end else if ((TIMEOUT != 0) && (hold_q == HOLD_MAX)) begin
                    release_c = 1'b1;
                    tmo_d     = 1'b1;
                end else if (TIMEOUT != 0) begin
                    hold_d = hold_q + HOLD_W'(1);
                end

                if (release_c) begin
                    ptr_d = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + IDX_W'(1);
                    if (GUARD_CYCLES > 0) begin
                        guard_d = GUARD_LOAD;
                        state_d = ARB_GUARD;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            ARB_GUARD: begin
                guard_d = guard_q - GUARD_W'(1);
                if (guard_q <= GUARD_W'(1)) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
            guard_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            guard_q  <= guard_d;
            tmo_q    <= tmo_d;
        end
    end

    // Grant outputs decode registered state only; start is the sole Mealy output.
    assign busy          = (state_q == ARB_GRANT);
    assign gnt           = busy ? (N_REQ'(1) << gnt_id_q) : '0;
    assign gnt_id        = gnt_id_q;
    assign start         = (state_q == ARB_IDLE) && (|req);
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter: directed scenarios plus randomized
// traffic against a behavioural owner/gap model.
module tb_rr_resource_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int GRD = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       start;
    logic       timeout_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Observation word: {gnt[3:0], gnt_id[1:0], busy, start, timeout_pulse}
    typedef logic [8:0] obs_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] d;
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       s;
        logic       t;
    } vec_t;

    rr_resource_arbiter #(
        .N_REQ        (N),
        .TIMEOUT      (TMO),
        .GUARD_CYCLES (GRD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .start         (start),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // gnt_id is only meaningful while busy, so it is masked by the expected busy.
    function automatic obs_t expv(logic [3:0] g, logic [1:0] id, logic b, logic s, logic t);
        return {g, (b ? id : 2'b00), b, s, t};
    endfunction

    function automatic obs_t got(logic b);
        return {gnt, (b ? gnt_id : 2'b00), busy, start, timeout_pulse};
    endfunction

    function automatic vec_t mk(logic [3:0] r, logic [3:0] d, logic [3:0] g,
                                logic [1:0] id, logic b, logic s, logic t);
        vec_t v;
        v.r = r; v.d = d; v.g = g; v.id = id; v.b = b; v.s = s; v.t = t;
        return v;
    endfunction

    // Drive inputs on the falling edge and let them settle before sampling.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req  = r;
        done = d;
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        reset = 1'b1;
        req   = 4'b0000;
        done  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        e = expv(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got(1'b0) !== e) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", got(1'b0), e);
        end
        n_cmp++;
        if (gnt_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        vec_t q[$];
        q.push_back(mk(4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b1100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(4'b1100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(4'b1100, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        foreach (q[i]) begin
            obs_t e;
            step(q[i].r, q[i].d);
            e = expv(q[i].g, q[i].id, q[i].b, q[i].s, q[i].t);
            n_cmp++;
            if (got(q[i].b) !== e) begin
                n_err++;
                $display("FAIL single[%0d]: got %b expected %b", i, got(q[i].b), e);
            end
        end
    endtask

    task automatic test_round_robin();
        vec_t q[$];
        int   order[5] = '{0, 1, 2, 3, 0};
        foreach (order[k]) begin
            logic [3:0] oh;
            logic [1:0] id;
            oh = 4'(1 << order[k]);
            id = 2'(order[k]);
            q.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
            q.push_back(mk(4'b1111, 4'b0000, oh,      id,   1'b1, 1'b0, 1'b0));
            q.push_back(mk(4'b1111, oh,      oh,      id,   1'b1, 1'b0, 1'b0));
            q.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        end
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        foreach (q[i]) begin
            obs_t e;
            step(q[i].r, q[i].d);
            e = expv(q[i].g, q[i].id, q[i].b, q[i].s, q[i].t);
            n_cmp++;
            if (got(q[i].b) !== e) begin
                n_err++;
                $display("FAIL round_robin[%0d]: got %b expected %b", i, got(q[i].b), e);
            end
        end
    endtask

    // ptr is 1 on entry; owner 0 never releases, requester 1 waits.
    task automatic test_timeout();
        vec_t q[$];
        q.push_back(mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        for (int c = 1; c <= TMO; c++)
            q.push_back(mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        foreach (q[i]) begin
            obs_t e;
            step(q[i].r, q[i].d);
            e = expv(q[i].g, q[i].id, q[i].b, q[i].s, q[i].t);
            n_cmp++;
            if (got(q[i].b) !== e) begin
                n_err++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, got(q[i].b), e);
            end
        end
    endtask

    // ptr is 2 on entry; a foreign done is ignored and done on the last hold cycle beats timeout.
    task automatic test_done_vs_timeout();
        vec_t q[$];
        q.push_back(mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        for (int c = 1; c < TMO; c++)
            q.push_back(mk(4'b0001, (c == 5) ? 4'b0010 : 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        foreach (q[i]) begin
            obs_t e;
            step(q[i].r, q[i].d);
            e = expv(q[i].g, q[i].id, q[i].b, q[i].s, q[i].t);
            n_cmp++;
            if (got(q[i].b) !== e) begin
                n_err++;
                $display("FAIL done_vs_timeout[%0d]: got %b expected %b", i, got(q[i].b), e);
            end
        end
    endtask

    // ptr is 1 on entry; owner 2 drops req, so the next full request set goes to 3.
    task automatic test_abandon();
        vec_t q[$];
        q.push_back(mk(4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        foreach (q[i]) begin
            obs_t e;
            step(q[i].r, q[i].d);
            e = expv(q[i].g, q[i].id, q[i].b, q[i].s, q[i].t);
            n_cmp++;
            if (got(q[i].b) !== e) begin
                n_err++;
                $display("FAIL abandon[%0d]: got %b expected %b", i, got(q[i].b), e);
            end
        end
    endtask

    // ptr is 0 on entry; grant requester 1, then reset mid-cycle while it owns the resource.
    task automatic test_reset_mid_grant();
        obs_t e;
        step(4'b0010, 4'b0000);
        step(4'b0010, 4'b0000);
        e = expv(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got(1'b1) !== e) begin
            n_err++;
            $display("FAIL rst_mid_owner: got %b expected %b", got(1'b1), e);
        end
        #2;
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        e = expv(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got(1'b0) !== e || gnt_id !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mid_async: got %b id %0d expected %b id 0", got(1'b0), gnt_id, e);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (got(1'b0) !== e) begin
            n_err++;
            $display("FAIL rst_mid_held: got %b expected %b", got(1'b0), e);
        end
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0011;
        #1;
        e = expv(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (got(1'b0) !== e) begin
            n_err++;
            $display("FAIL rst_mid_restart: got %b expected %b", got(1'b0), e);
        end
        step(4'b0011, 4'b0000);
        e = expv(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got(1'b1) !== e) begin
            n_err++;
            $display("FAIL rst_mid_ptr0: got %b expected %b", got(1'b1), e);
        end
        step(4'b0000, 4'b0001);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
    endtask

    // Randomized traffic scored against an owner / gap / pointer model.
    task automatic test_random();
        int         owner    = -1;
        int         held     = 0;
        int         gap      = 0;
        int         ptr      = 0;
        int         last_id  = 0;
        logic       tmo_flag = 1'b0;
        logic [3:0] r        = 4'b0000;
        logic [3:0] d;

        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        done  = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            obs_t e;
            logic exp_busy, exp_start, tmo_next;
            logic [3:0] exp_gnt;

            if ($urandom_range(0, 3) == 0) begin
                int b;
                b = $urandom_range(0, 3);
                r[b] = ~r[b];
            end
            d = 4'b0000;
            if (owner >= 0 && $urandom_range(0, 9) == 0) d[owner] = 1'b1;
            if ($urandom_range(0, 7) == 0) d = d | 4'($urandom);
            if (owner >= 0 && $urandom_range(0, 29) == 0) r[owner] = 1'b0;

            step(r, d);

            exp_busy  = (owner >= 0);
            exp_gnt   = exp_busy ? 4'(1 << owner) : 4'b0000;
            exp_start = !exp_busy && (gap == 0) && (r != 4'b0000);
            e = expv(exp_gnt, 2'(last_id), exp_busy, exp_start, tmo_flag);
            n_cmp++;
            if (got(exp_busy) !== e) begin
                n_err++;
                $display("FAIL random[%0d]: got %b expected %b (req %b done %b)",
                         cyc, got(exp_busy), e, r, d);
            end

            tmo_next = 1'b0;
            if (exp_busy) begin
                if (d[owner] || !r[owner] || (TMO != 0 && held == TMO)) begin
                    tmo_next = !d[owner] && r[owner];
                    ptr      = (owner + 1) % N;
                    owner    = -1;
                    gap      = GRD;
                end else begin
                    held++;
                end
            end else if (gap > 0) begin
                gap--;
            end else if (r != 4'b0000) begin
                for (int i = 0; i < N; i++)
                    if (owner < 0 && r[(ptr + i) % N]) owner = (ptr + i) % N;
                held    = 1;
                last_id = owner;
            end
            tmo_flag = tmo_next;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_vs_timeout();
        test_abandon();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
